// File: rtl/chirp_ctrl_pkg.sv
// Shared types and constants for the chirp burst sequencer and its counters.
package chirp_ctrl_pkg;

  localparam int CHIRP_IDX_W      = 16;
  localparam int DEFAULT_ADC_TAIL = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARM      = 3'd1;
  localparam logic [2:0] ST_WAIT_RDY = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_TAIL     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  typedef enum logic [2:0] {
    SEQ_IDLE     = ST_IDLE,
    SEQ_ARM      = ST_ARM,
    SEQ_WAIT_RDY = ST_WAIT_RDY,
    SEQ_RUN      = ST_RUN,
    SEQ_TAIL     = ST_TAIL,
    SEQ_GAP      = ST_GAP
  } chirp_seq_state_t;

  // A burst of zero chirps runs as a single chirp.
  function automatic logic [CHIRP_IDX_W-1:0] last_chirp_index(input logic [CHIRP_IDX_W-1:0] n);
    return (n == '0) ? '0 : n - CHIRP_IDX_W'(1);
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero; zero_o reflects the registered count.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/chirp_burst_sequencer.sv
// Steps the chirp DDS and ADC capture window through a burst of chirps with
// DDS tail hold, inter-chirp gap, ready timeout, abort and FIFO throttling.
module chirp_burst_sequencer
  import chirp_ctrl_pkg::*;
#(
  parameter int ADC_TAIL      = DEFAULT_ADC_TAIL,
  parameter int READY_TIMEOUT = 1024,
  parameter int GAP_WIDTH     = 32
) (
  input  logic                   clk_245_i,
  input  logic                   clk_245_rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   continuous_i,
  input  logic [CHIRP_IDX_W-1:0] num_chirps_i,
  input  logic [GAP_WIDTH-1:0]   gap_cycles_i,
  input  logic                   chirp_ready_i,
  input  logic                   chirp_done_i,
  input  logic                   chirp_active_i,
  input  logic                   adc_fifo_almost_full_i,
  output logic                   chirp_init_o,
  output logic                   chirp_enable_o,
  output logic                   adc_enable_o,
  output logic                   busy_o,
  output logic                   burst_done_o,
  output logic                   timeout_err_o,
  output logic [CHIRP_IDX_W-1:0] chirp_index_o
);

  localparam int TO_W      = $clog2(READY_TIMEOUT + 1);
  localparam int TAIL_W    = $clog2(ADC_TAIL + 2);
  // Counters exit on zero, so they are loaded with one less than the hold length.
  localparam int TAIL_LOAD = (ADC_TAIL > 0) ? ADC_TAIL - 1 : 0;

  chirp_seq_state_t       state_q, state_d;
  logic [CHIRP_IDX_W-1:0] num_q, num_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [CHIRP_IDX_W-1:0] idx_q, idx_d;
  logic                   abort_pend_q, abort_pend_d;
  logic                   to_err_q, to_err_d;
  logic                   chirp_init_q, chirp_init_d;
  logic                   burst_done_q, burst_done_d;
  logic                   chirp_en_q, adc_en_q, busy_q;

  logic to_load, to_en, to_zero;
  logic tail_load, tail_en, tail_zero;
  logic gap_load, gap_en, gap_zero;
  logic abort_now, last_chirp;

  down_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .clk_i      (clk_245_i),
    .rst_i      (clk_245_rst_i),
    .load_i     (to_load),
    .load_val_i (TO_W'(READY_TIMEOUT)),
    .en_i       (to_en),
    .zero_o     (to_zero)
  );

  down_counter #(.WIDTH(TAIL_W)) u_tail_cnt (
    .clk_i      (clk_245_i),
    .rst_i      (clk_245_rst_i),
    .load_i     (tail_load),
    .load_val_i (TAIL_W'(TAIL_LOAD)),
    .en_i       (tail_en),
    .zero_o     (tail_zero)
  );

  down_counter #(.WIDTH(GAP_WIDTH)) u_gap_cnt (
    .clk_i      (clk_245_i),
    .rst_i      (clk_245_rst_i),
    .load_i     (gap_load),
    .load_val_i (gap_q - GAP_WIDTH'(1)),
    .en_i       (gap_en),
    .zero_o     (gap_zero)
  );

  assign abort_now  = abort_i | abort_pend_q;
  assign last_chirp = !continuous_i && (idx_q == last_chirp_index(num_q));

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    gap_d        = gap_q;
    idx_d        = idx_q;
    abort_pend_d = abort_pend_q;
    to_err_d     = to_err_q;
    chirp_init_d = 1'b0;
    burst_done_d = 1'b0;
    to_load      = 1'b0;
    to_en        = 1'b0;
    tail_load    = 1'b0;
    tail_en      = 1'b0;
    gap_load     = 1'b0;
    gap_en       = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        abort_pend_d = 1'b0;
        if (start_i) begin
          num_d    = num_chirps_i;
          gap_d    = gap_cycles_i;
          idx_d    = '0;
          to_err_d = 1'b0;
          state_d  = SEQ_ARM;
        end
      end
      SEQ_ARM: begin
        if (abort_now) begin
          burst_done_d = 1'b1;
          state_d      = SEQ_IDLE;
        end else if (!adc_fifo_almost_full_i) begin
          chirp_init_d = 1'b1;
          to_load      = 1'b1;
          state_d      = SEQ_WAIT_RDY;
        end
      end
      SEQ_WAIT_RDY: begin
        if (abort_now) begin
          burst_done_d = 1'b1;
          state_d      = SEQ_IDLE;
        end else if (chirp_ready_i) begin
          state_d = SEQ_RUN;
        end else if (to_zero) begin
          to_err_d     = 1'b1;
          burst_done_d = 1'b1;
          state_d      = SEQ_IDLE;
        end else begin
          to_en = 1'b1;
        end
      end
      SEQ_RUN: begin
        // Abort closes the chirp like a done so the capture tail is never cut short.
        if (chirp_done_i || abort_i) begin
          abort_pend_d = abort_pend_q | abort_i;
          tail_load    = 1'b1;
          state_d      = SEQ_TAIL;
        end
      end
      SEQ_TAIL: begin
        abort_pend_d = abort_now;
        if (!tail_zero) begin
          tail_en = 1'b1;
        end else if (last_chirp || abort_now) begin
          burst_done_d = 1'b1;
          state_d      = SEQ_IDLE;
        end else begin
          idx_d = idx_q + CHIRP_IDX_W'(1);
          if (gap_q == '0) begin
            state_d = SEQ_ARM;
          end else begin
            gap_load = 1'b1;
            state_d  = SEQ_GAP;
          end
        end
      end
      SEQ_GAP: begin
        if (abort_now) begin
          burst_done_d = 1'b1;
          state_d      = SEQ_IDLE;
        end else if (gap_zero) begin
          state_d = SEQ_ARM;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_245_i) begin
    if (clk_245_rst_i) begin
      state_q      <= SEQ_IDLE;
      num_q        <= '0;
      gap_q        <= '0;
      idx_q        <= '0;
      abort_pend_q <= 1'b0;
      to_err_q     <= 1'b0;
      chirp_init_q <= 1'b0;
      burst_done_q <= 1'b0;
      chirp_en_q   <= 1'b0;
      adc_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      gap_q        <= gap_d;
      idx_q        <= idx_d;
      abort_pend_q <= abort_pend_d;
      to_err_q     <= to_err_d;
      chirp_init_q <= chirp_init_d;
      burst_done_q <= burst_done_d;
      chirp_en_q   <= (state_d == SEQ_RUN);
      adc_en_q     <= (state_d == SEQ_RUN) || (state_d == SEQ_TAIL);
      busy_q       <= (state_d != SEQ_IDLE);
    end
  end

  assign chirp_init_o   = chirp_init_q;
  assign chirp_enable_o = chirp_en_q;
  assign adc_enable_o   = adc_en_q;
  assign busy_o         = busy_q;
  assign burst_done_o   = burst_done_q;
  assign timeout_err_o  = to_err_q;
  assign chirp_index_o  = idx_q;

  a_active_in_run: assert property (@(posedge clk_245_i) disable iff (clk_245_rst_i)
    chirp_active_i |-> (state_q == SEQ_RUN || state_q == SEQ_TAIL));

endmodule

// File: tb/tb_chirp_burst_sequencer.sv
// Directed scenarios against a timeline model of the sequencer built from its timing rules.
module tb_chirp_burst_sequencer;

  localparam int TAIL = 2;
  localparam int TMO  = 1024;
  localparam int MAXC = 1100;
  localparam int NSC  = 11;

  typedef struct {
    int ts, num, gap; bit cont; int rdy, clen, af_lo, af_hi, ab, rc, stray, len; bit keep, pre_to;
  } scen_t;
  typedef struct { int s, c, sig, v; } pin_t;

  logic        clk = 1'b0;
  logic        rst, start, abort_in, cont, ready, done, active, af;
  logic [15:0] num;
  logic [31:0] gap;
  logic        init_o, en_o, adc_o, busy_o, bd_o, to_o;
  logic [15:0] idx_o;

  chirp_burst_sequencer #(.ADC_TAIL(TAIL), .READY_TIMEOUT(TMO), .GAP_WIDTH(32)) dut (
    .clk_245_i(clk), .clk_245_rst_i(rst), .start_i(start), .abort_i(abort_in),
    .continuous_i(cont), .num_chirps_i(num), .gap_cycles_i(gap),
    .chirp_ready_i(ready), .chirp_done_i(done), .chirp_active_i(active),
    .adc_fifo_almost_full_i(af), .chirp_init_o(init_o), .chirp_enable_o(en_o),
    .adc_enable_o(adc_o), .busy_o(busy_o), .burst_done_o(bd_o),
    .timeout_err_o(to_o), .chirp_index_o(idx_o)
  );

  always #2 clk = ~clk;

  int exp_init[MAXC], exp_en[MAXC], exp_adc[MAXC], exp_busy[MAXC];
  int exp_bd[MAXC], exp_to[MAXC], exp_idx[MAXC];
  scen_t sc[NSC];
  pin_t  pins[$];
  int    n_chk = 0, n_fail = 0, cyc = 0, scen = 0;
  bit    chk_on = 1'b0;

  function automatic scen_t mk(int ts, int nm, int gp, bit ct, int rd, int cl, int al, int ah,
                               int ab, int rc, int st, int ln, bit kp, bit pt);
    scen_t p;
    p.ts = ts; p.num = nm; p.gap = gp; p.cont = ct; p.rdy = rd; p.clen = cl;
    p.af_lo = al; p.af_hi = ah; p.ab = ab; p.rc = rc; p.stray = st; p.len = ln;
    p.keep = kp; p.pre_to = pt;
    return p;
  endfunction

  // Expected waveforms from the burst timing rules: init two cycles after start or
  // one after the gap, enables one cycle after ready, capture tail of TAIL cycles.
  task automatic plan(input scen_t p);
    int arm, a, init, r, e, d, u, idx, lastidx, end_c;
    for (int k = 0; k < MAXC; k++) begin
      exp_init[k] = 0; exp_en[k] = 0; exp_adc[k] = 0; exp_busy[k] = 0;
      exp_bd[k] = 0; exp_idx[k] = 0; exp_to[k] = (k <= p.ts) ? int'(p.pre_to) : 0;
    end
    arm = p.ts + 1; idx = 0; lastidx = (p.num == 0) ? 0 : p.num - 1; end_c = -1;
    while (end_c < 0) begin
      a = arm;
      while (a >= p.af_lo && a < p.af_hi) a++;
      if (p.ab >= arm && p.ab <= a) begin end_c = p.ab + 1; break; end
      init = a + 1;
      exp_init[init] = 1;
      r = (p.rdy < 0) ? 32'h3fff_ffff : init + p.rdy;
      if (p.ab >= init && p.ab <= ((r < init + TMO) ? r : init + TMO)) begin end_c = p.ab + 1; break; end
      if (r > init + TMO) begin
        end_c = init + TMO + 1;
        for (int k = end_c; k < MAXC; k++) exp_to[k] = 1;
        break;
      end
      e = r + 1;
      d = e + p.clen - 1;
      if (p.ab >= e && p.ab < d) d = p.ab;
      u = d + 1 + TAIL;
      for (int k = e; k <= d && k < MAXC; k++) exp_en[k] = 1;
      for (int k = e; k < u && k < MAXC; k++) exp_adc[k] = 1;
      if ((p.ab >= e && p.ab < u) || (!p.cont && idx == lastidx)) begin end_c = u; break; end
      idx = (idx + 1) & 16'hffff;
      for (int k = u; k < MAXC; k++) exp_idx[k] = idx;
      if (p.ab >= u && p.ab < u + p.gap) begin end_c = p.ab + 1; break; end
      arm = u + p.gap;
    end
    for (int k = p.ts + 1; k < end_c && k < MAXC; k++) exp_busy[k] = 1;
    if (end_c < MAXC) exp_bd[end_c] = 1;
    if (p.rc >= 0) begin
      for (int k = p.rc + 1; k < MAXC; k++) begin
        exp_init[k] = 0; exp_en[k] = 0; exp_adc[k] = 0; exp_busy[k] = 0;
        exp_bd[k] = 0; exp_to[k] = 0; exp_idx[k] = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s scen=%0d cyc=%0d got=%0d want=%0d", nm, scen, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] dut_sig(input int code);
    case (code)
      0: return {31'd0, init_o};
      1: return {31'd0, en_o};
      2: return {31'd0, adc_o};
      3: return {31'd0, busy_o};
      4: return {31'd0, bd_o};
      5: return {31'd0, to_o};
      default: return {16'd0, idx_o};
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("chirp_init", {31'd0, init_o}, exp_init[cyc]);
      chk("chirp_enable", {31'd0, en_o}, exp_en[cyc]);
      chk("adc_enable", {31'd0, adc_o}, exp_adc[cyc]);
      chk("busy", {31'd0, busy_o}, exp_busy[cyc]);
      chk("burst_done", {31'd0, bd_o}, exp_bd[cyc]);
      chk("timeout_err", {31'd0, to_o}, exp_to[cyc]);
      chk("chirp_index", {16'd0, idx_o}, exp_idx[cyc]);
      foreach (pins[i])
        if (pins[i].s == scen && pins[i].c == cyc)
          chk($sformatf("pin_sig%0d", pins[i].sig), dut_sig(pins[i].sig), pins[i].v);
    end
  end

  initial begin
    int rdy_at, en_cnt;
    //        ts num gap ct rdy clen afl afh  ab   rc  str  len kp pt
    sc[0]  = mk(2, 3, 10, 0, 3, 100, -1, -1, -1, -1, -1, 360, 0, 0);
    sc[1]  = mk(2, 0, 5,  0, 3, 20,  -1, -1, -1, -1, -1, 50,  0, 0);
    sc[2]  = mk(2, 2, 0,  0, 3, 10,  -1, -1, -1, -1, -1, 50,  0, 0);
    sc[3]  = mk(2, 2, 10, 0, 3, 10,  30, 80, -1, -1, 25, 110, 0, 0);
    sc[4]  = mk(2, 1, 0,  0, -1, 10, -1, -1, -1, -1, -1, 1040, 0, 0);
    sc[5]  = mk(2, 1, 4,  1, 3, 30,  -1, -1, 100, -1, -1, 120, 1, 1);
    sc[6]  = mk(2, 2, 3,  0, 3, 50,  -1, -1, -1, 20, -1, 40,  0, 0);
    sc[7]  = mk(2, 1, 0,  0, 2, 5,   3,  6,  2,  -1, -1, 30,  0, 0);
    sc[8]  = mk(2, 1, 0,  0, 6, 10,  -1, -1, 7,  -1, -1, 20,  0, 0);
    sc[9]  = mk(2, 3, 5,  0, 3, 10,  -1, -1, 18, -1, -1, 40,  0, 0);
    sc[10] = mk(2, 3, 10, 0, 3, 10,  -1, -1, 24, -1, -1, 40,  0, 0);
    // sig codes: 0 init, 1 enable, 2 adc, 3 busy, 4 burst_done, 5 timeout_err, 6 index
    pins = '{'{0,0,3,0}, '{0,3,0,0}, '{0,4,0,1}, '{0,8,1,1}, '{0,108,1,0}, '{0,109,2,1},
             '{0,110,2,0}, '{0,121,0,1}, '{0,227,6,2}, '{0,343,3,1}, '{0,344,4,1}, '{0,344,3,0},
             '{1,29,3,1}, '{1,30,4,1}, '{1,30,3,0}, '{2,20,0,0}, '{2,21,0,1}, '{2,37,4,1},
             '{3,31,0,0}, '{3,81,0,1}, '{3,97,4,1}, '{4,1028,5,0}, '{4,1028,3,1},
             '{4,1029,5,1}, '{4,1029,4,1}, '{5,2,5,1}, '{5,3,5,0}, '{5,81,6,2}, '{5,86,0,1},
             '{5,100,1,1}, '{5,101,1,0}, '{5,102,2,1}, '{5,103,2,0}, '{5,103,4,1},
             '{6,20,1,1}, '{6,21,1,0}, '{6,21,2,0}, '{6,21,3,0}, '{7,7,0,1}, '{7,17,4,1},
             '{8,8,4,1}, '{8,8,3,0}, '{9,19,2,1}, '{9,20,4,1}, '{10,25,4,1}, '{10,25,6,1}};

    rst = 1'b1; start = 1'b0; abort_in = 1'b0; cont = 1'b0; ready = 1'b0; done = 1'b0;
    active = 1'b0; af = 1'b0; num = '0; gap = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < NSC; s++) begin
      plan(sc[s]);
      scen = s;
      start = 1'b0; abort_in = 1'b0; ready = 1'b0; done = 1'b0; active = 1'b0; af = 1'b0;
      if (!sc[s].keep) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
      end
      rst = 1'b0;
      rdy_at = -1; en_cnt = 0;
      num = 16'(sc[s].num); gap = 32'(sc[s].gap); cont = sc[s].cont;
      chk_on = 1'b1;
      for (int k = 0; k < sc[s].len; k++) begin
        cyc = k;
        start    = (k == sc[s].ts);
        abort_in = (k == sc[s].ab);
        af       = (k >= sc[s].af_lo && k < sc[s].af_hi);
        rst      = (k == sc[s].rc);
        if (init_o === 1'b1 && sc[s].rdy >= 0) rdy_at = k + sc[s].rdy;
        ready = (k == rdy_at);
        if (en_o === 1'b1) en_cnt++; else en_cnt = 0;
        done   = (en_cnt == sc[s].clen) || (k == sc[s].stray);
        active = (en_o === 1'b1);
        @(posedge clk);
        #1;
      end
      chk_on = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
